// File: rtl/fetch_unit.sv
// fetch_unit: RV32I program counter and single-outstanding instruction fetch sequencer.
// Supplies pc+4 to the next-PC mux and hands fetched words to decode over valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   input  logic        redirect,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } fetchState;

   fetchState   state;
   logic        drop;
   logic [31:0] reqPc;
   logic [31:0] redirectPc;

   assign redirectPc     = {pc_next[31:2], 2'b00};
   assign pc_plus4       = pc + 32'd4;
   assign imem_req_addr  = pc;
   assign imem_req_valid = (state == REQ);

   // NOTE: every register here is written with <= so all branches see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= REQ;
         pc         <= RESET_PC;
         drop       <= 1'b0;
         reqPc      <= 32'h0;
         inst_valid <= 1'b0;
         inst_data  <= 32'h0;
         inst_pc    <= 32'h0;
      end else begin
         if (redirect) begin
            pc <= redirectPc;
         end
         case (state)
            REQ: begin
               if (imem_req_ready) begin
                  // A redirect racing the acceptance leaves a stale request in flight.
                  reqPc <= pc;
                  drop  <= redirect;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  drop <= 1'b0;
                  if (!drop && !redirect) begin
                     inst_data  <= imem_rsp_data;
                     inst_pc    <= reqPc;
                     inst_valid <= 1'b1;
                     state      <= HOLD;
                  end else begin
                     state <= REQ;
                  end
               end else if (redirect) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect || inst_ready) begin
                  inst_valid <= 1'b0;
                  state      <= REQ;
                  if (!redirect) begin
                     pc <= pc_next;
                  end
               end
            end
            default: begin
               state <= REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit against a transaction-level model of
// the fetch rules (one outstanding request, one buffered instruction, stale-response drop).
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int nVec;
   int nMis;
   int cyc;

   // Model of the fetch path: what has been requested, what is buffered for decode.
   bit          modelReady;
   logic [31:0] mPc;
   bit          mOut;
   bit          mStale;
   logic [31:0] mOutAddr;
   bit          mBufV;
   logic [31:0] mBufD;
   logic [31:0] mBufPc;
   int          memCnt;
   int          rspDelay;
   logic [31:0] accQ[$];
   int          accCyc[$];
   logic [31:0] hsQ[$];

   // The next-PC mux sitting in front of the fetch unit.
   assign pc_next = redirect ? target : pc_plus4;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_next        (pc_next),
      .redirect       (redirect),
      .pc_plus4       (pc_plus4),
      .pc             (pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin : modelStep
      logic        fire;
      logic [31:0] oldPc;
      if (reset) begin
         mPc        = RST_PC;
         mOut       = 1'b0;
         mStale     = 1'b0;
         mOutAddr   = 32'h0;
         mBufV      = 1'b0;
         mBufD      = 32'h0;
         mBufPc     = 32'h0;
         memCnt     = 0;
         modelReady = 1'b1;
      end else if (modelReady) begin
         oldPc = mPc;
         fire  = !mOut && !mBufV && imem_req_ready;
         if (mBufV) begin
            if (redirect) begin
               mBufV = 1'b0;
            end else if (inst_ready) begin
               mBufV = 1'b0;
               mPc   = mPc + 32'd4;
               hsQ.push_back(mBufPc);
            end
         end
         if (mOut && imem_rsp_valid) begin
            mOut = 1'b0;
            if (!mStale && !redirect) begin
               mBufV  = 1'b1;
               mBufD  = imem_rsp_data;
               mBufPc = mOutAddr;
            end
            mStale = 1'b0;
         end else if (mOut && redirect) begin
            mStale = 1'b1;
         end
         if (memCnt == 1) memCnt = 0;
         else if (memCnt > 1) memCnt--;
         if (fire) begin
            mOut     = 1'b1;
            mStale   = redirect;
            mOutAddr = oldPc;
            memCnt   = rspDelay;
            accQ.push_back(oldPc);
            accCyc.push_back(cyc);
         end
         if (redirect) mPc = {target[31:2], 2'b00};
      end
   end

   always @(negedge clk) begin
      if (modelReady) begin
         check("req_valid", 32'(imem_req_valid), 32'(!mOut && !mBufV));
         if (!mOut && !mBufV) check("req_addr", imem_req_addr, mPc);
         check("pc", pc, mPc);
         check("pc_plus4", pc_plus4, mPc + 32'd4);
         check("inst_valid", 32'(inst_valid), 32'(mBufV));
         if (mBufV) begin
            check("inst_data", inst_data, mBufD);
            check("inst_pc", inst_pc, mBufPc);
         end
      end
   end

   // Drive the memory response for this cycle, then advance one clock.
   task automatic step();
      imem_rsp_valid = (memCnt == 1);
      imem_rsp_data  = (memCnt == 1) ? memWord(mOutAddr) : 32'h0;
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int accBase;
      int hsBase;
      nVec = 0; nMis = 0; cyc = 0;
      modelReady = 1'b0; rspDelay = 1; memCnt = 0;
      mOut = 1'b0; mBufV = 1'b0; mStale = 1'b0;
      mPc = 32'h0; mOutAddr = 32'h0; mBufD = 32'h0; mBufPc = 32'h0;
      reset = 1'b1; redirect = 1'b0; target = 32'h0;
      imem_req_ready = 1'b1; inst_ready = 1'b1;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      @(negedge clk);
      repeat (3) step();
      check("rst_pc", pc, 32'h0000_0100);
      check("rst_req_valid", 32'(imem_req_valid), 32'd1);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_data", inst_data, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);

      // Streaming at full rate: one instruction every 3 cycles.
      reset = 1'b0;
      accBase = accQ.size();
      hsBase  = hsQ.size();
      repeat (9) step();
      check("stream_addr0", accQ[accBase], 32'h0000_0100);
      check("stream_addr1", accQ[accBase + 1], 32'h0000_0104);
      check("stream_addr2", accQ[accBase + 2], 32'h0000_0108);
      check("stream_gap", 32'(accCyc[accBase + 2] - accCyc[accBase]), 32'd6);
      check("stream_hs0", hsQ[hsBase], 32'h0000_0100);
      check("stream_hs2", hsQ[hsBase + 2], 32'h0000_0108);
      check("stream_pc", pc, 32'h0000_010C);

      // Decode stalls in HOLD.
      inst_ready = 1'b0;
      step();
      step();
      hsBase = hsQ.size();
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", 32'(inst_valid), 32'd1);
         check("stall_inst_pc", inst_pc, 32'h0000_010C);
         check("stall_inst_data", inst_data, memWord(32'h0000_010C));
         check("stall_no_req", 32'(imem_req_valid), 32'd0);
         check("stall_pc", pc, 32'h0000_010C);
      end
      inst_ready = 1'b1;
      step();
      check("stall_release_pc", pc, 32'h0000_0110);
      check("stall_release_hs", 32'(hsQ.size() - hsBase), 32'd1);

      // Redirect while waiting, response arrives two cycles later.
      hsBase = hsQ.size();
      rspDelay = 3;
      step();
      rspDelay = 1;
      redirect = 1'b1; target = 32'h0000_2000;
      step();
      redirect = 1'b0;
      check("wait_redir_pc", pc, 32'h0000_2000);
      check("wait_redir_noreq", 32'(imem_req_valid), 32'd0);
      step();
      check("wait_redir_still_wait", 32'(imem_req_valid), 32'd0);
      step();
      check("wait_redir_req", 32'(imem_req_valid), 32'd1);
      check("wait_redir_addr", imem_req_addr, 32'h0000_2000);
      check("wait_redir_noinst", 32'(inst_valid), 32'd0);

      // Redirect coinciding with the response.
      step();
      redirect = 1'b1; target = 32'h0000_0040;
      step();
      redirect = 1'b0;
      check("rsp_redir_req", 32'(imem_req_valid), 32'd1);
      check("rsp_redir_addr", imem_req_addr, 32'h0000_0040);
      check("rsp_redir_noinst", 32'(inst_valid), 32'd0);
      check("rsp_redir_nohs", 32'(hsQ.size() - hsBase), 32'd0);
      step();
      check("rsp_redir_acc", accQ[accQ.size() - 1], 32'h0000_0040);

      // Redirect in HOLD together with a decode handshake.
      step();
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst_pc", inst_pc, 32'h0000_0040);
      redirect = 1'b1; target = 32'h0000_0080;
      step();
      redirect = 1'b0;
      check("hold_redir_invalid", 32'(inst_valid), 32'd0);
      check("hold_redir_addr", imem_req_addr, 32'h0000_0080);
      check("hold_redir_nohs", 32'(hsQ.size() - hsBase), 32'd0);
      step();

      // PC wrap at the top of the address space; low target bits are dropped.
      step();
      redirect = 1'b1; target = 32'hFFFF_FFFE;
      step();
      redirect = 1'b0;
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'h0000_0000);
      step();
      step();
      step();
      check("wrap_hs", hsQ[hsQ.size() - 1], 32'hFFFF_FFFC);
      check("wrap_next_pc", pc, 32'h0000_0000);
      check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

      // Reset while waiting for a response.
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_pc", pc, 32'h0000_0100);
      check("midrst_req", 32'(imem_req_valid), 32'd1);
      check("midrst_inst_valid", 32'(inst_valid), 32'd0);

      // Redirect in REQ without and with a same-cycle acceptance.
      imem_req_ready = 1'b0;
      redirect = 1'b1; target = 32'h0000_0300;
      step();
      redirect = 1'b0;
      check("req_redir_pc", pc, 32'h0000_0300);
      check("req_redir_addr", imem_req_addr, 32'h0000_0300);
      imem_req_ready = 1'b1;
      redirect = 1'b1; target = 32'h0000_0400;
      step();
      redirect = 1'b0;
      check("req_acc_redir_pc", pc, 32'h0000_0400);
      check("req_acc_redir_noreq", 32'(imem_req_valid), 32'd0);
      step();
      check("req_acc_redir_req", 32'(imem_req_valid), 32'd1);
      check("req_acc_redir_addr", imem_req_addr, 32'h0000_0400);
      check("req_acc_redir_noinst", 32'(inst_valid), 32'd0);
      step();
      step();
      step();
      check("final_hs", hsQ[hsQ.size() - 1], 32'h0000_0400);
      check("final_pc", pc, 32'h0000_0404);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
